// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared sizing and pointer-wrap helpers for the fifo family.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Modulo-depth increment; wraps by compare so any depth is legal.
    function automatic int ptr_next(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wrap_ptr.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wrap_ptr
// Purpose  : Enabled pointer register that wraps from DEPTH-1 back to 0.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [PTR_W-1:0] o_ptr
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (i_en) begin
            ptr_d = PTR_W'(ptr_next(int'(ptr_q), DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign o_ptr = ptr_q;

endmodule
`default_nettype wire

// File: rtl/fifo_flex.sv
`default_nettype none
// ============================================================================
// Module   : fifo_flex
// Purpose  : Single-clock FIFO, any DEPTH >= 2, standard or FWFT read path,
//            registered status flags and overflow/underflow error pulses.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_flex
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          rd,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int c_cw = cnt_width(DEPTH);
    localparam int c_pw = $clog2(DEPTH);
    localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);
    localparam logic [c_cw-1:0] c_af    = c_cw'(AF_THRESH);
    localparam logic [c_cw-1:0] c_ae    = c_cw'(AE_THRESH);

    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic [c_pw-1:0]       w_wptr;
    logic [c_pw-1:0]       w_rptr;

    logic [c_cw-1:0]       count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Flags are recomputed from the next count so they stay registered
    // with no combinational path from wr/rd.
    always_comb begin
        w_rd_ok = rd && !empty_q;
        w_wr_ok = wr && (!full_q || w_rd_ok);
        count_d = count_q;
        case ({w_wr_ok, w_rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == c_depth);
        empty_d = (count_d == '0);
        af_d    = (count_d >= c_af);
        ae_d    = (count_d <= c_ae);
        ovf_d   = wr && !w_wr_ok;
        unf_d   = rd && !w_rd_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    fifo_wrap_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (c_pw)
    ) u_wptr (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_wr_ok),
        .o_ptr (w_wptr)
    );

    fifo_wrap_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (c_pw)
    ) u_rptr (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_rd_ok),
        .o_ptr (w_rptr)
    );

    // Storage is deliberately left unreset; occupancy tracking guards reads.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) begin
            mem[w_wptr] <= data_in;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign data_out = mem[w_rptr];
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;
        logic [DATA_WIDTH-1:0] dout_d;

        always_comb begin
            dout_d = dout_q;
            if (w_rd_ok) begin
                dout_d = mem[w_rptr];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q <= '0;
            end else begin
                dout_q <= dout_d;
            end
        end

        assign data_out = dout_q;
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_flex.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_flex
// Purpose  : Scoreboard bench: a standard-mode DEPTH=5 FIFO and an FWFT
//            DEPTH=4 FIFO share stimulus and are checked against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_flex;

    localparam int D0 = 5, AF0 = 3, AE0 = 1;
    localparam int D1 = 4, AF1 = 3, AE1 = 1;

    typedef struct {
        int cnt;
        bit full;
        bit empty;
        bit af;
        bit ae;
        bit ovf;
        bit unf;
        bit fv;
        int dout;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr  = 1'b0;
    logic       rd  = 1'b0;
    logic [7:0] din = '0;

    logic [7:0] dout0, dout1;
    logic       full0, full1, empty0, empty1;
    logic       af0, af1, ae0, ae1, ovf0, ovf1, unf0, unf1;
    logic [2:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    // Reference model: circular storage with explicit head/size per instance.
    int mdata [2][8];
    int mhead [2];
    int msize [2];
    int mlast0;

    exp_t sq0[$];
    exp_t sq1[$];

    always #5 clk = ~clk;

    fifo_flex #(
        .DATA_WIDTH (8), .DEPTH (D0), .FWFT (0), .AF_THRESH (AF0), .AE_THRESH (AE0)
    ) u_std (
        .clk (clk), .rst (rst), .wr (wr), .data_in (din), .rd (rd),
        .data_out (dout0), .full (full0), .empty (empty0),
        .almost_full (af0), .almost_empty (ae0), .count (cnt0),
        .overflow (ovf0), .underflow (unf0)
    );

    fifo_flex #(
        .DATA_WIDTH (8), .DEPTH (D1), .FWFT (1), .AF_THRESH (AF1), .AE_THRESH (AE1)
    ) u_fwft (
        .clk (clk), .rst (rst), .wr (wr), .data_in (din), .rd (rd),
        .data_out (dout1), .full (full1), .empty (empty1),
        .almost_full (af1), .almost_empty (ae1), .count (cnt1),
        .overflow (ovf1), .underflow (unf1)
    );

    task automatic model_step(input int k, input bit r, input bit w, input bit rq,
                              input int d, output exp_t e);
        int  dep;
        int  af;
        int  ae;
        bit  rd_ok;
        bit  wr_ok;
        dep = (k == 0) ? D0 : D1;
        af  = (k == 0) ? AF0 : AF1;
        ae  = (k == 0) ? AE0 : AE1;
        e.ovf = 1'b0;
        e.unf = 1'b0;
        if (r) begin
            mhead[k] = 0;
            msize[k] = 0;
            if (k == 0) mlast0 = 0;
        end else begin
            rd_ok = rq && (msize[k] > 0);
            wr_ok = w && ((msize[k] < dep) || rd_ok);
            if (rd_ok) begin
                if (k == 0) mlast0 = mdata[k][mhead[k]];
                mhead[k] = (mhead[k] + 1) % dep;
                msize[k] = msize[k] - 1;
            end
            if (wr_ok) begin
                mdata[k][(mhead[k] + msize[k]) % dep] = d;
                msize[k] = msize[k] + 1;
            end
            e.ovf = w && !wr_ok;
            e.unf = rq && !rd_ok;
        end
        e.cnt   = msize[k];
        e.full  = (msize[k] == dep);
        e.empty = (msize[k] == 0);
        e.af    = (msize[k] >= af);
        e.ae    = (msize[k] <= ae);
        e.fv    = (k == 0) ? 1'b1 : (msize[k] > 0);
        e.dout  = (k == 0) ? mlast0 : mdata[k][mhead[k]];
    endtask

    // One clock of stimulus: drive after the edge, queue the post-edge state.
    task automatic cyc(input bit r, input bit w, input bit rq, input int d);
        exp_t e;
        @(posedge clk);
        #2;
        rst = r;
        wr  = w;
        rd  = rq;
        din = d[7:0];
        model_step(0, r, w, rq, d & 255, e);
        sq0.push_back(e);
        model_step(1, r, w, rq, d & 255, e);
        sq1.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp_v);
        end
    endtask

    task automatic check_inst(input int k, input exp_t e);
        string p;
        p = (k == 0) ? "std" : "fwft";
        chk({p, ".count"},        (k == 0) ? int'(cnt0)  : int'(cnt1),  e.cnt);
        chk({p, ".full"},         (k == 0) ? int'(full0) : int'(full1), int'(e.full));
        chk({p, ".empty"},        (k == 0) ? int'(empty0): int'(empty1),int'(e.empty));
        chk({p, ".almost_full"},  (k == 0) ? int'(af0)   : int'(af1),   int'(e.af));
        chk({p, ".almost_empty"}, (k == 0) ? int'(ae0)   : int'(ae1),   int'(e.ae));
        chk({p, ".overflow"},     (k == 0) ? int'(ovf0)  : int'(ovf1),  int'(e.ovf));
        chk({p, ".underflow"},    (k == 0) ? int'(unf0)  : int'(unf1),  int'(e.unf));
        if (e.fv) begin
            chk({p, ".data_out"}, (k == 0) ? int'(dout0) : int'(dout1), e.dout);
        end
    endtask

    // Monitor: one expectation per clock, compared just after the edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sq0.size() > 0) begin
                e = sq0.pop_front();
                check_inst(0, e);
            end
            if (sq1.size() > 0) begin
                e = sq1.pop_front();
                check_inst(1, e);
            end
        end
    end

    initial begin : stimulus
        int pw;
        int pr;
        // Reset, including requests that must be ignored during reset.
        cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 3);
        // Fill, overflow, drain, underflow with held data.
        for (int i = 1; i <= 5; i++) cyc(0, 1, 0, i);
        cyc(0, 1, 0, 6);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        // Interleaved write/read pairs across pointer wrap.
        for (int i = 0; i < 12; i++) begin
            cyc(0, 1, 0, i);
            cyc(0, 0, 1, 0);
        end
        // Simultaneous write/read at full, then drain.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 10 + i);
        cyc(0, 1, 1, 20);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0);
        // Simultaneous write/read at empty.
        cyc(0, 1, 1, 9);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        // Threshold walk then reset at count 3.
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 40 + i);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        // Randomised phases with different fill pressure.
        for (int ph = 0; ph < 12; ph++) begin
            pw = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 50 : 25);
            pr = (ph % 3 == 0) ? 25 : ((ph % 3 == 1) ? 50 : 80);
            for (int i = 0; i < 50; i++) begin
                cyc(($urandom_range(0, 79) == 0),
                    ($urandom_range(0, 99) < pw),
                    ($urandom_range(0, 99) < pr),
                    int'($urandom_range(0, 255)));
            end
        end
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            if (sq0.size() != 0 || sq1.size() != 0) @(posedge clk);
        end
        #3;
        chk("scoreboard_drained", sq0.size() + sq1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_flex.md
# fifo_flex

Parametrised synchronous FIFO, the next generation of the team's single-clock `fifo`. It adds any `DEPTH >= 2` (not only powers of two) and a selectable first-word-fall-through (FWFT) read mode. It also provides an occupancy count, programmable almost-full/almost-empty flags, and overflow/underflow error pulses. It sits between any producer/consumer pair in one clock domain.

## Interface
- `DATA_WIDTH`, 8: word width in bits (>= 1).
- `DEPTH`, 8: number of storage words (>= 2, any integer).
- `FWFT`, 0: 0 = standard registered read; 1 = first-word-fall-through.
- `AF_THRESH`, DEPTH-1: `almost_full` asserts when count >= AF_THRESH (1..DEPTH).
- `AE_THRESH`, 1: `almost_empty` asserts when count <= AE_THRESH (0..DEPTH-1).
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `wr` in 1: write request.
- `data_in` in DATA_WIDTH: write data, sampled with `wr`.
- `rd` in 1: read request (FWFT: pop/acknowledge of `data_out`).
- `data_out` out DATA_WIDTH: read data.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `almost_full` out 1: count >= AF_THRESH.
- `almost_empty` out 1: count <= AE_THRESH.
- `count` out CW = $clog2(DEPTH+1): words stored.
- `overflow` out 1: one-cycle pulse, rejected write.
- `underflow` out 1: one-cycle pulse, rejected read.

## Operation
- Acceptance per edge:
  - `rd_ok = rd && !empty`.
  - `wr_ok = wr && (!full || rd_ok)`. A write when full is accepted only with a same-cycle accepted read.
  - A read when empty is rejected even if `wr` is high. The write is still accepted.
- Write: `mem[wptr] <= data_in`; wptr advances.
- Read: rptr advances.
- Pointers wrap from DEPTH-1 to 0 by compare, not by bit overflow, so a non-power-of-two `DEPTH` is legal.
- Count update: +1 (wr_ok only), -1 (rd_ok only), unchanged (both or neither). Count never leaves 0..DEPTH.
- Standard mode (`FWFT=0`): on rd_ok, `data_out <= mem[rptr]`. Otherwise `data_out` holds its value.
- FWFT mode (`FWFT=1`): `data_out = mem[rptr]` combinationally. It is valid whenever `!empty` and don't-care when empty. `rd` consumes the displayed word.
- Error pulses:
  - `overflow <= wr && !wr_ok`.
  - `underflow <= rd && !rd_ok`.
  - Both are registered and high for exactly one cycle per offending request. FIFO state is unchanged by the rejected operation.
- Reset: wptr=rptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=underflow=0, standard-mode `data_out`=0. Memory contents are not reset.
- Reset mid-operation discards all contents. Requests in the reset cycle are ignored and produce no error pulse.

## Timing
- All status outputs (`full`, `empty`, `almost_*`, `count`) are registered. They reflect the state after edge N in cycle N+1, with no combinational path from `wr`/`rd`.
- Write-to-read latency: a word written at edge N is readable (`empty` low) from edge N+1.
- Standard-mode read latency: data appears 1 cycle after the accepting edge.
- FWFT-mode read latency: data is visible in the same cycle `empty` deasserts.
- `overflow`/`underflow` are high in the cycle after the offending edge.
- Throughput: one write and one read per cycle sustained at any fill level, including full (simultaneous) and depth 1..DEPTH-1.

## Structure
- Package `fifo_pkg`: function `cnt_width(depth)` returning $clog2(depth+1), plus `ptr_next(ptr, depth)` wrap helper. `fifo_flex` and legacy benches share these.
- Sub-module `fifo_wrap_ptr`: a pointer register with enable and modulo-DEPTH wrap, instanced twice (write, read).
- Memory is an unpacked array inside `fifo_flex`, with a generate split for the `FWFT` read path.

## Test plan
- Fill/drain, DEPTH=5, DATA_WIDTH=4, FWFT=0:
  - Write 1,2,3,4,5: `full`=1 and `count`=5.
  - A sixth write of 6 gives an `overflow` pulse.
  - Reading 5 times returns 1,2,3,4,5 and `empty`=1.
  - A sixth read gives an `underflow` pulse and `data_out` holds 5.
- Wrap-around, DEPTH=5: run 12 interleaved write/read pairs of 0..11. Output order is 0..11 and `count` never exceeds 1.
- Simultaneous at full, DEPTH=4: fill with A,B,C,D, then wr=rd=1 with E. Read returns A, `count` stays 4, no overflow, and subsequent drain gives B,C,D,E.
- Simultaneous at empty: wr=rd=1 with 9. The result is an underflow pulse and `count`=1, and the next read returns 9.
- FWFT=1, DEPTH=4: write 7. The next cycle shows `data_out`=7 with `empty`=0 before any `rd`. Then `rd` gives `empty`=1.
- Thresholds and reset, AF=3, AE=1:
  - At count 1: `almost_empty`=1.
  - At count 2: both flags 0.
  - At count 3: `almost_full`=1.
  - Asserting `rst` at count 3 gives count 0, `empty`=1 and no error pulses the next cycle.
